regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Writeback-side driver of the register file's single write port (a3/we3/wd3).
//  Merges results from two producers (src0 = ALU pipe, src1 = LSU/long-latency)
//  via valid/ready, one skid entry each, and issues at most one write per cycle.
//  Keeps a per-register pending scoreboard that decode queries for RAW hazards.
// PARAMETERS
//  XLen      32              data width of a write
//  NReg      32              architectural registers; x0 is hardwired zero
//  NRegWidth $clog2(NReg)    register index width
// PORTS
//  clk_i        in   1          clock
//  rst_ni       in   1          async active-low reset
//  s0_valid_i   in   1          src0 result valid
//  s0_ready_o   out  1          src0 may hand over a result
//  s0_rd_i      in   NRegWidth  src0 destination register
//  s0_data_i    in   XLen       src0 result
//  s1_valid_i   in   1          src1 result valid
//  s1_ready_o   out  1          src1 may hand over a result
//  s1_rd_i      in   NRegWidth  src1 destination register
//  s1_data_i    in   XLen       src1 result
//  claim_i      in   1          issue stage marks claim_rd_i as pending
//  claim_rd_i   in   NRegWidth  register being claimed
//  a1_i, a2_i   in   NRegWidth  decode source registers to check
//  hazard1_o    out  1          a1_i has a pending write
//  hazard2_o    out  1          a2_i has a pending write
//  we3_o        out  1          register-file write enable (registered)
//  a3_o         out  NRegWidth  write address (registered)
//  wd3_o        out  XLen       write data (registered)
// BEHAVIOUR
//  - One clock (clk_i); reset async active-low (rst_ni). Reset: skids empty,
//    pending all 0, we3_o=0, a3_o=0, wd3_o=0; s*_ready_o=1, hazard*_o=0.
//    Reset mid-operation discards skid contents and any write in flight.
//  - Handshake: transfer at a rising edge where valid&&ready. Producer holds
//    rd/data stable while valid&&!ready. sN_ready_o = skidN empty OR skidN
//    granted this cycle (back-to-back transfers, 1/cycle per source).
//  - rd==0 transfers complete normally but are dropped: skid not loaded,
//    no write generated.
//  - Each cycle the arbiter grants one occupied skid; at the next edge the
//    output register loads {we3_o=1,a3_o=rd,wd3_o=data} and the skid frees
//    (or reloads if a new transfer occurs the same edge). No grant -> we3_o=0
//    next cycle; a3_o/wd3_o hold last value.
//  - Latency: transfer at edge E0 -> we3_o high in cycle after E1 (if
//    uncontended); register file commits at E2.
//  - Arbitration (default): fixed priority, src0 over src1; a loser keeps
//    its entry and its ready stays low until granted.
//  - Scoreboard pending[NReg]: set at the edge where claim_i=1 and
//    claim_rd_i!=0; cleared at the edge where we3_o=1 for a3_o (the commit
//    edge). Same-register set and clear on one edge: set wins.
//    claim_rd_i==0 ignored.
//  - hazardN_o = pending[aN_i] && aN_i!=0, combinational; stays 1 through
//    the cycle we3_o is high, so decode never reads a stale value.
// CONFIGURATION
//  WB_RR_ARB_EN defined: round-robin between src0/src1; last-grant pointer
//   resets to favour src0, flips only when both contend. Not defined:
//   fixed src0 priority as above (src1 can starve under continuous src0).
// TESTING
//  1 reset asserted mid-stream -> we3_o=0,a3_o=0,wd3_o=0 immediately; both
//    ready=1, hazards 0.
//  2 s0 rd=5 data=32'hDEADBEEF at E0 -> we3_o=1,a3_o=5,wd3_o=32'hDEADBEEF
//    for exactly the cycle after E1.
//  3 s0 rd=3 data=32'h11 and s1 rd=4 data=32'h22 same edge -> writes to 3
//    then 4 on consecutive cycles; s1_ready_o=0 one cycle.
//  4 s1 rd=0 data=32'hFF -> handshake completes, we3_o stays 0 for 5 cycles.
//  5 claim rd=7, a1_i=7 -> hazard1_o=1 until commit edge of write to 7;
//    re-claim 7 on that edge -> hazard1_o stays 1.
//  6 both sources valid 8 cycles -> with WB_RR_ARB_EN grants alternate
//    0,1,0,1...; without it all 8 writes from src0, s1_ready_o=0 throughout.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter driving the register file's single write port from two skid-buffered producers,
// with a pending-write scoreboard for RAW hazard checks. Define WB_RR_ARB_EN for round-robin arbitration.
module regfile_wb_arbiter #(
  parameter int unsigned XLen      = 32,
  parameter int unsigned NReg      = 32,
  parameter int unsigned NRegWidth = $clog2(NReg)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 s0_valid_i,
  output logic                 s0_ready_o,
  input  logic [NRegWidth-1:0] s0_rd_i,
  input  logic [XLen-1:0]      s0_data_i,
  input  logic                 s1_valid_i,
  output logic                 s1_ready_o,
  input  logic [NRegWidth-1:0] s1_rd_i,
  input  logic [XLen-1:0]      s1_data_i,
  input  logic                 claim_i,
  input  logic [NRegWidth-1:0] claim_rd_i,
  input  logic [NRegWidth-1:0] a1_i,
  input  logic [NRegWidth-1:0] a2_i,
  output logic                 hazard1_o,
  output logic                 hazard2_o,
  output logic                 we3_o,
  output logic [NRegWidth-1:0] a3_o,
  output logic [XLen-1:0]      wd3_o
);

  logic                 skid0_valid_q, skid0_valid_d;
  logic                 skid1_valid_q, skid1_valid_d;
  logic [NRegWidth-1:0] skid0_rd_q, skid0_rd_d, skid1_rd_q, skid1_rd_d;
  logic [XLen-1:0]      skid0_data_q, skid0_data_d, skid1_data_q, skid1_data_d;
  logic                 we3_q, we3_d;
  logic [NRegWidth-1:0] a3_q, a3_d;
  logic [XLen-1:0]      wd3_q, wd3_d;
  logic [NReg-1:0]      pending_q, pending_d;
  logic                 gnt0, gnt1, s0_fire, s1_fire;
`ifdef WB_RR_ARB_EN
  logic                 favour_s1_q, favour_s1_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
`ifdef WB_RR_ARB_EN
    favour_s1_d = favour_s1_q;
    gnt0        = skid0_valid_q && (!skid1_valid_q || !favour_s1_q);
    gnt1        = skid1_valid_q && (!skid0_valid_q ||  favour_s1_q);
    if (skid0_valid_q && skid1_valid_q) favour_s1_d = !favour_s1_q;
`else
    gnt0 = skid0_valid_q;
    gnt1 = skid1_valid_q && !skid0_valid_q;
`endif

    s0_ready_o = !skid0_valid_q || gnt0;
    s1_ready_o = !skid1_valid_q || gnt1;
    s0_fire    = s0_valid_i && s0_ready_o;
    s1_fire    = s1_valid_i && s1_ready_o;

    // A granted entry frees; a same-edge transfer to a nonzero rd reloads it. rd==0 is swallowed.
    skid0_valid_d = skid0_valid_q && !gnt0;
    skid0_rd_d    = skid0_rd_q;
    skid0_data_d  = skid0_data_q;
    if (s0_fire && s0_rd_i != '0) begin
      skid0_valid_d = 1'b1;
      skid0_rd_d    = s0_rd_i;
      skid0_data_d  = s0_data_i;
    end

    skid1_valid_d = skid1_valid_q && !gnt1;
    skid1_rd_d    = skid1_rd_q;
    skid1_data_d  = skid1_data_q;
    if (s1_fire && s1_rd_i != '0) begin
      skid1_valid_d = 1'b1;
      skid1_rd_d    = s1_rd_i;
      skid1_data_d  = s1_data_i;
    end

    we3_d = gnt0 || gnt1;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (gnt0) begin
      a3_d  = skid0_rd_q;
      wd3_d = skid0_data_q;
    end else if (gnt1) begin
      a3_d  = skid1_rd_q;
      wd3_d = skid1_data_q;
    end

    // Clear on the commit edge first, then apply the claim so a same-register re-claim wins.
    pending_d = pending_q;
    if (we3_q) pending_d[a3_q] = 1'b0;
    if (claim_i && claim_rd_i != '0) pending_d[claim_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      skid0_valid_q <= 1'b0;
      skid1_valid_q <= 1'b0;
      we3_q         <= 1'b0;
      a3_q          <= '0;
      wd3_q         <= '0;
      pending_q     <= '0;
    end else begin
      skid0_valid_q <= skid0_valid_d;
      skid1_valid_q <= skid1_valid_d;
      we3_q         <= we3_d;
      a3_q          <= a3_d;
      wd3_q         <= wd3_d;
      pending_q     <= pending_d;
    end
  end

  // NOTE: skid payload is only meaningful while its valid flop is set, so it needs no reset.
  always_ff @(posedge clk_i) begin
    skid0_rd_q   <= skid0_rd_d;
    skid0_data_q <= skid0_data_d;
    skid1_rd_q   <= skid1_rd_d;
    skid1_data_q <= skid1_data_d;
  end

`ifdef WB_RR_ARB_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) favour_s1_q <= 1'b0;
    else         favour_s1_q <= favour_s1_d;
  end
`endif

  assign hazard1_o = pending_q[a1_i] && (a1_i != '0);
  assign hazard2_o = pending_q[a2_i] && (a2_i != '0);
  assign we3_o     = we3_q;
  assign a3_o      = a3_q;
  assign wd3_o     = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations follow WB_RR_ARB_EN when defined.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s0_valid_i = 1'b0, s1_valid_i = 1'b0, claim_i = 1'b0;
  logic        s0_ready_o, s1_ready_o, hazard1_o, hazard2_o, we3_o;
  logic [4:0]  s0_rd_i = '0, s1_rd_i = '0, claim_rd_i = '0, a1_i = '0, a2_i = '0, a3_o;
  logic [31:0] s0_data_i = '0, s1_data_i = '0, wd3_o;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_valid_i(s0_valid_i), .s0_ready_o(s0_ready_o), .s0_rd_i(s0_rd_i), .s0_data_i(s0_data_i),
    .s1_valid_i(s1_valid_i), .s1_ready_o(s1_ready_o), .s1_rd_i(s1_rd_i), .s1_data_i(s1_data_i),
    .claim_i(claim_i), .claim_rd_i(claim_rd_i), .a1_i(a1_i), .a2_i(a2_i),
    .hazard1_o(hazard1_o), .hazard2_o(hazard2_o),
    .we3_o(we3_o), .a3_o(a3_o), .wd3_o(wd3_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle; inputs driven here transfer at the following edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  initial begin
    int    nwr;
    int    c0, c1;
    logic  f0, f1;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    // Reset state
    #2;
    check("rst_we3", we3_o, 0);
    check("rst_rdy0", s0_ready_o, 1);
    check("rst_rdy1", s1_ready_o, 1);
    step();
    rst_ni = 1'b1;
    step();

    // Single src0 write: rd=5
    s0_valid_i = 1; s0_rd_i = 5; s0_data_i = 32'hDEADBEEF;
    check("t2_rdy0", s0_ready_o, 1);
    step();
    s0_valid_i = 0;
    check("t2_we3_e0", we3_o, 0);
    step();
    check("t2_we3", we3_o, 1);
    check("t2_a3", a3_o, 5);
    check("t2_wd3", wd3_o, 32'hDEADBEEF);
    step();
    check("t2_we3_off", we3_o, 0);
    check("t2_a3_hold", a3_o, 5);

    // Simultaneous src0/src1: 3 then 4
    s0_valid_i = 1; s0_rd_i = 3; s0_data_i = 32'h11;
    s1_valid_i = 1; s1_rd_i = 4; s1_data_i = 32'h22;
    step();
    s0_valid_i = 0; s1_valid_i = 0;
    check("t3_rdy1_low", s1_ready_o, 0);
    check("t3_rdy0", s0_ready_o, 1);
    step();
    check("t3_we3_a", we3_o, 1);
    check("t3_a3_a", a3_o, 3);
    check("t3_wd3_a", wd3_o, 32'h11);
    check("t3_rdy1_back", s1_ready_o, 1);
    step();
    check("t3_we3_b", we3_o, 1);
    check("t3_a3_b", a3_o, 4);
    check("t3_wd3_b", wd3_o, 32'h22);
    step();
    check("t3_idle", we3_o, 0);

    // rd=0 from src1 is accepted and dropped
    s1_valid_i = 1; s1_rd_i = 0; s1_data_i = 32'hFF;
    check("t4_rdy1", s1_ready_o, 1);
    step();
    s1_valid_i = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_we3_%0d", i), we3_o, 0);
      step();
    end
    check("t4_rdy1_after", s1_ready_o, 1);

    // Scoreboard on register 7
    a1_i = 7; a2_i = 0;
    claim_i = 1; claim_rd_i = 7;
    check("t5_haz_preclaim", hazard1_o, 0);
    step();
    claim_i = 0;
    check("t5_haz_set", hazard1_o, 1);
    check("t5_haz2_x0", hazard2_o, 0);
    a2_i = 7;
    #1 check("t5_haz2_set", hazard2_o, 1);
    s0_valid_i = 1; s0_rd_i = 7; s0_data_i = 32'h77;
    step();
    s0_valid_i = 0;
    check("t5_haz_e0", hazard1_o, 1);
    step();
    check("t5_we3", we3_o, 1);
    check("t5_a3", a3_o, 7);
    check("t5_haz_wb", hazard1_o, 1);
    claim_i = 1; claim_rd_i = 7;
    step();
    claim_i = 0;
    check("t5_haz_reclaim", hazard1_o, 1);
    s0_valid_i = 1; s0_rd_i = 7; s0_data_i = 32'h78;
    step();
    s0_valid_i = 0;
    step();
    check("t5_we3_2", we3_o, 1);
    check("t5_haz_wb2", hazard1_o, 1);
    step();
    check("t5_haz_clr", hazard1_o, 0);
    check("t5_haz2_clr", hazard2_o, 0);
    claim_i = 1; claim_rd_i = 0; a1_i = 0;
    step();
    claim_i = 0;
    check("t5_claim_x0", hazard1_o, 0);

    // Both sources stream continuously
    c0 = 0; c1 = 0; nwr = 0;
    s0_rd_i = 10; s1_rd_i = 20;
    s0_data_i = 32'hA00; s1_data_i = 32'hB00;
    s0_valid_i = 1; s1_valid_i = 1;
    for (int it = 0; it < 20 && nwr < 8; it++) begin
      #1;
`ifndef WB_RR_ARB_EN
      if (it > 0) check($sformatf("t6_rdy1_low_%0d", it), s1_ready_o, 0);
`endif
      f0 = s0_valid_i && s0_ready_o;
      f1 = s1_valid_i && s1_ready_o;
      step();
      if (f0) begin c0++; s0_data_i = 32'hA00 + c0; end
      if (f1) begin c1++; s1_data_i = 32'hB00 + c1; end
      if (we3_o) begin
`ifdef WB_RR_ARB_EN
        exp_rd   = (nwr % 2 == 0) ? 5'd10 : 5'd20;
        exp_data = (nwr % 2 == 0) ? 32'hA00 + nwr / 2 : 32'hB00 + nwr / 2;
`else
        exp_rd   = 5'd10;
        exp_data = 32'hA00 + nwr;
`endif
        check($sformatf("t6_a3_%0d", nwr), a3_o, exp_rd);
        check($sformatf("t6_wd3_%0d", nwr), wd3_o, exp_data);
        nwr++;
      end
    end
    check("t6_nwr", nwr, 8);
    s0_valid_i = 0; s1_valid_i = 0;

    // Reset mid-stream with writes in flight and a register pending
    a1_i = 12;
    claim_i = 1; claim_rd_i = 12;
    step();
    claim_i = 0;
    check("t1_haz_pre", hazard1_o, 1);
    s0_valid_i = 1; s0_rd_i = 9;  s0_data_i = 32'h99;
    s1_valid_i = 1; s1_rd_i = 11; s1_data_i = 32'hBB;
    step();
    s0_valid_i = 0; s1_valid_i = 0;
    step();
    check("t1_we3_pre", we3_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("t1_we3", we3_o, 0);
    check("t1_a3", a3_o, 0);
    check("t1_wd3", wd3_o, 0);
    check("t1_rdy0", s0_ready_o, 1);
    check("t1_rdy1", s1_ready_o, 1);
    check("t1_haz1", hazard1_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    check("t1_discard_a", we3_o, 0);
    step();
    check("t1_discard_b", we3_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
